// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl
// Sequences one radix-2 Cooley-Tukey NTT stage over an N = 2**LOG_N point
// coefficient RAM. After a start request it issues one butterfly pair per
// cycle (N/2 pairs, no bubbles). It produces the two read addresses and the
// twiddle address for each pair, and delays the read addresses by the RAM
// read latency plus the butterfly latency so that the write-back addresses
// line up with the butterfly outputs.
//
// Parameters
//   LOG_N      : log2 of the transform size N
//   RD_LATENCY : coefficient-RAM read latency in cycles
//   BF_LATENCY : butterfly input-to-output latency in cycles
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   rst        : asynchronous, active-high reset
//   start      : one-cycle request to run one stage
//   stage      : stage index s, sampled only when start is accepted
//   busy       : high from the cycle after acceptance through the done cycle
//   done       : one-cycle pulse after the last write-back is issued
//   rd_en      : coefficient-RAM read enable, one butterfly pair per cycle
//   rd_addr_a  : read address of butterfly input a
//   rd_addr_b  : read address of butterfly input b
//   tw_addr    : twiddle-ROM address, aligned with rd_en
//   wr_en      : write enable for butterfly outputs A and B
//   wr_addr_a  : write-back address of output A
//   wr_addr_b  : write-back address of output B
//
// All address outputs are 0 whenever their enable is low.

module ntt_stage_ctrl #(
    parameter int LOG_N      = 10,
    parameter int RD_LATENCY = 1,
    parameter int BF_LATENCY = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       stage,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    output logic [LOG_N-1:0] tw_addr,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b
);

    localparam int N_INT = 1 << LOG_N;
    localparam int HALF  = N_INT / 2;
    localparam int L     = RD_LATENCY + BF_LATENCY;

    localparam logic [LOG_N-1:0] K_LAST = LOG_N'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [LOG_N-1:0] k_q;
    logic [3:0]       stage_q;
    logic             pending_q;

    logic             start_ok;
    logic             k_last;
    logic             later_valid;

    logic [LOG_N-1:0] t_val;
    logic [LOG_N-1:0] m_val;
    logic [LOG_N-1:0] i_val;
    logic [LOG_N-1:0] j_val;
    logic [LOG_N-1:0] base_a;
    logic [LOG_N-1:0] base_b;
    logic [LOG_N-1:0] base_tw;

    logic [L-1:0]     pipe_v;
    logic [LOG_N-1:0] pipe_a [L];
    logic [LOG_N-1:0] pipe_b [L];

    // A start only counts when the stage index names a real stage; anything
    // else is dropped without leaving a trace.
    assign start_ok = start && (32'(stage) < LOG_N);
    assign k_last   = (k_q == K_LAST);

    // Looks for any pair still in flight behind the one at the pipeline
    // output. When the output is valid and nothing follows it, that output
    // is the last write-back of the stage.
    always_comb begin
        later_valid = 1'b0;
        for (int i = 0; i < L - 1; i++) begin
            later_valid = later_valid | pipe_v[i];
        end
    end

    // State register. Reset drops straight to IDLE so an interrupted stage
    // never resumes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A start that was caught during DONE is remembered in
    // pending_q and launches the next stage from IDLE one cycle later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pending_q || start_ok) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (k_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_en && !later_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pair counter, latched stage index and the pending-start flag. The
    // stage is latched either on a direct start in IDLE or on a start that
    // lands in the DONE cycle. In the second case the previous stage has
    // finished issuing, so overwriting stage_q there is harmless. The
    // counter holds at its last value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q       <= '0;
            stage_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        k_q       <= '0;
                        pending_q <= 1'b0;
                    end else if (start_ok) begin
                        k_q     <= '0;
                        stage_q <= stage;
                    end
                end
                ISSUE: begin
                    if (!k_last) begin
                        k_q <= k_q + LOG_N'(1);
                    end
                end
                DONE: begin
                    if (start_ok) begin
                        stage_q   <= stage;
                        pending_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Cooley-Tukey pair addressing for pair k of stage s.
    //   t = N >> (s+1) : distance between a and b
    //   m = 2**s       : first twiddle index of this stage
    //   i = group of k : k >> (LOG_N-1-s)
    //   j = offset     : k & (t-1)
    // a = (i << (LOG_N-s)) | j,  b = a + t,  tw = m + i.
    // Every shift amount stays in range because stage_q < LOG_N.
    always_comb begin
        t_val   = LOG_N'(N_INT >> (32'(stage_q) + 1));
        m_val   = LOG_N'(1) << stage_q;
        i_val   = k_q >> (LOG_N - 1 - 32'(stage_q));
        j_val   = k_q & (t_val - LOG_N'(1));
        base_a  = (i_val << (LOG_N - 32'(stage_q))) | j_val;
        base_b  = base_a + t_val;
        base_tw = m_val + i_val;
    end

    // Write-back alignment pipeline. It carries the already-gated read
    // addresses and the read strobe for RD_LATENCY + BF_LATENCY cycles.
    // Reset clears every valid bit, so an aborted stage writes nothing
    // afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < L; i++) begin
                pipe_a[i] <= '0;
                pipe_b[i] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_en;
            pipe_a[0] <= rd_addr_a;
            pipe_b[0] <= rd_addr_b;
            for (int i = 1; i < L; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end

    // Output decode. Every output is a pure function of registered state,
    // so asserting reset clears all of them in the same instant.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        rd_en     = (state_q == ISSUE);
        rd_addr_a = rd_en ? base_a  : '0;
        rd_addr_b = rd_en ? base_b  : '0;
        tw_addr   = rd_en ? base_tw : '0;
        wr_en     = pipe_v[L-1];
        wr_addr_a = wr_en ? pipe_a[L-1] : '0;
        wr_addr_b = wr_en ? pipe_b[L-1] : '0;
    end

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// tb_ntt_stage_ctrl
// Directed bench for ntt_stage_ctrl with LOG_N=3, RD_LATENCY=1 and
// BF_LATENCY=6, giving a write-back delay of 7 cycles. Cycle 0 is the cycle
// in which start is driven. Outputs are sampled 1 time unit after each
// rising edge. The expected pair/twiddle tables are written out by hand for
// each stage.

module tb_ntt_stage_ctrl;

    localparam int LOG_N = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] stage;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [2:0] tw_addr;
    logic       wr_en;
    logic [2:0] wr_addr_a;
    logic [2:0] wr_addr_b;

    int checks;
    int failures;

    ntt_stage_ctrl #(
        .LOG_N      (LOG_N),
        .RD_LATENCY (1),
        .BF_LATENCY (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stage     (stage),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [3:0] stg);
        start = st;
        stage = stg;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"}, 32'(busy), 0);
        checkOutput({tag, " done"}, 32'(done), 0);
        checkOutput({tag, " rd_en"}, 32'(rd_en), 0);
        checkOutput({tag, " rd_addr_a"}, 32'(rd_addr_a), 0);
        checkOutput({tag, " rd_addr_b"}, 32'(rd_addr_b), 0);
        checkOutput({tag, " tw_addr"}, 32'(tw_addr), 0);
        checkOutput({tag, " wr_en"}, 32'(wr_en), 0);
        checkOutput({tag, " wr_addr_a"}, 32'(wr_addr_a), 0);
        checkOutput({tag, " wr_addr_b"}, 32'(wr_addr_b), 0);
    endtask

    // Drives start for stage s in the current cycle (cycle 0) and checks
    // every output up to and including the done cycle. first is the cycle
    // of the first rd_en: 1 for a start from IDLE, 2 for a start caught in
    // DONE. With poke set, an extra start for stage 1 is driven in cycle 3
    // (ISSUE) and cycle 6 (DRAIN). Both must be ignored.
    task automatic runStage(input logic [3:0] s, input int first, input logic poke,
                            input logic [0:3][2:0] ea, input logic [0:3][2:0] eb,
                            input logic [0:3][2:0] etw);
        logic       rd_exp;
        logic       wr_exp;
        logic [2:0] a_exp;
        logic [2:0] b_exp;
        logic [2:0] tw_exp;
        logic [2:0] wa_exp;
        logic [2:0] wb_exp;
        string      tag;
        applyStimulus(1'b1, s);
        for (int c = 1; c <= first + 11; c++) begin
            tick();
            if (poke && (c == 3 || c == 6)) begin
                applyStimulus(1'b1, 4'd1);
            end else begin
                applyStimulus(1'b0, s);
            end
            rd_exp = (c >= first) && (c <= first + 3);
            wr_exp = (c >= first + 7) && (c <= first + 10);
            a_exp  = '0;
            b_exp  = '0;
            tw_exp = '0;
            wa_exp = '0;
            wb_exp = '0;
            if (rd_exp) begin
                a_exp  = ea[c - first];
                b_exp  = eb[c - first];
                tw_exp = etw[c - first];
            end
            if (wr_exp) begin
                wa_exp = ea[c - first - 7];
                wb_exp = eb[c - first - 7];
            end
            tag = $sformatf("s%0d c%0d", s, c);
            checkOutput({tag, " rd_en"}, 32'(rd_en), 32'(rd_exp));
            checkOutput({tag, " rd_addr_a"}, 32'(rd_addr_a), 32'(a_exp));
            checkOutput({tag, " rd_addr_b"}, 32'(rd_addr_b), 32'(b_exp));
            checkOutput({tag, " tw_addr"}, 32'(tw_addr), 32'(tw_exp));
            checkOutput({tag, " wr_en"}, 32'(wr_en), 32'(wr_exp));
            checkOutput({tag, " wr_addr_a"}, 32'(wr_addr_a), 32'(wa_exp));
            checkOutput({tag, " wr_addr_b"}, 32'(wr_addr_b), 32'(wb_exp));
            checkOutput({tag, " busy"}, 32'(busy), 32'((c >= first) && (c <= first + 11)));
            checkOutput({tag, " done"}, 32'(done), 32'(c == first + 11));
        end
    endtask

    // Directed sequence: reset, each stage, back-to-back, rejected starts,
    // and reset in the middle of a stage followed by a restart.
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(1'b0, 4'd0);

        tick();
        tick();
        $display("[TB] reset state");
        checkAllZero("reset");

        // rst released together with start: the very next edge must accept it
        rst = 1'b0;
        $display("[TB] stage 0");
        runStage(4'd0, 1, 1'b0, {3'd0, 3'd1, 3'd2, 3'd3}, {3'd4, 3'd5, 3'd6, 3'd7},
                 {3'd1, 3'd1, 3'd1, 3'd1});
        tick();
        checkOutput("idle after s0 busy", 32'(busy), 0);

        $display("[TB] stage 1");
        runStage(4'd1, 1, 1'b0, {3'd0, 3'd1, 3'd4, 3'd5}, {3'd2, 3'd3, 3'd6, 3'd7},
                 {3'd2, 3'd2, 3'd3, 3'd3});
        tick();

        $display("[TB] stage 2 then back-to-back stage 0");
        runStage(4'd2, 1, 1'b0, {3'd0, 3'd2, 3'd4, 3'd6}, {3'd1, 3'd3, 3'd5, 3'd7},
                 {3'd4, 3'd5, 3'd6, 3'd7});
        runStage(4'd0, 2, 1'b0, {3'd0, 3'd1, 3'd2, 3'd3}, {3'd4, 3'd5, 3'd6, 3'd7},
                 {3'd1, 3'd1, 3'd1, 3'd1});
        tick();

        $display("[TB] out-of-range stage");
        applyStimulus(1'b1, 4'd3);
        for (int c = 1; c <= 3; c++) begin
            tick();
            applyStimulus(1'b0, 4'd0);
            checkOutput($sformatf("bad stage c%0d rd_en", c), 32'(rd_en), 0);
            checkOutput($sformatf("bad stage c%0d busy", c), 32'(busy), 0);
            checkOutput($sformatf("bad stage c%0d done", c), 32'(done), 0);
        end

        $display("[TB] start while busy");
        runStage(4'd0, 1, 1'b1, {3'd0, 3'd1, 3'd2, 3'd3}, {3'd4, 3'd5, 3'd6, 3'd7},
                 {3'd1, 3'd1, 3'd1, 3'd1});
        tick();
        checkOutput("after poke busy", 32'(busy), 0);
        checkOutput("after poke rd_en", 32'(rd_en), 0);

        $display("[TB] reset mid-stage");
        applyStimulus(1'b1, 4'd0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            applyStimulus(1'b0, 4'd0);
        end
        checkOutput("pre-abort busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        checkAllZero("async reset");
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checkOutput($sformatf("aborted c%0d wr_en", c), 32'(wr_en), 0);
            checkOutput($sformatf("aborted c%0d done", c), 32'(done), 0);
            checkOutput($sformatf("aborted c%0d busy", c), 32'(busy), 0);
        end

        $display("[TB] restart after abort");
        runStage(4'd1, 1, 1'b0, {3'd0, 3'd1, 3'd4, 3'd5}, {3'd2, 3'd3, 3'd6, 3'd7},
                 {3'd2, 3'd2, 3'd3, 3'd3});
        tick();
        checkOutput("final idle busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ntt_stage_ctrl.md
NTT_STAGE_CTRL -- requirements
Module: ntt_stage_ctrl

Interface
REQ-001 SHALL have parameter LOG_N, default 10, meaning log2 of transform size N (N/2 butterflies per stage).
REQ-002 SHALL have parameter RD_LATENCY, default 1, meaning coefficient-RAM read latency in cycles.
REQ-003 SHALL have parameter BF_LATENCY, default 6, meaning butterfly input-to-output latency in cycles.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1, a one-cycle request to run one stage.
REQ-007 SHALL have port stage, input, 4, the stage index s, sampled only when start is accepted.
REQ-008 SHALL have port busy, output, 1, high while a stage is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when the stage's last write is issued.
REQ-010 SHALL have port rd_en, input-side strobe output, 1, the coefficient-RAM read enable.
REQ-011 SHALL have ports rd_addr_a and rd_addr_b, output, LOG_N each, the read addresses of the butterfly inputs a and b.
REQ-012 SHALL have port tw_addr, output, LOG_N, the twiddle-ROM address, aligned with rd_en.
REQ-013 SHALL have port wr_en, output, 1, the write enable for the butterfly outputs A and B.
REQ-014 SHALL have ports wr_addr_a and wr_addr_b, output, LOG_N each, the write-back addresses for A and B.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-016 SHALL go IDLE->ISSUE on start when stage < LOG_N, and ignore start when stage >= LOG_N or when not IDLE.
REQ-017 SHALL, on acceptance, latch s, clear pair counter k, and raise busy from the next cycle through the DONE cycle inclusive.
REQ-018 SHALL, in ISSUE, assert rd_en for exactly N/2 consecutive cycles, with k = 0..N/2-1, one pair per cycle and no bubbles.
REQ-019 SHALL address Cooley-Tukey style: t = N>>(s+1), m = 2^s, i = k>>(LOG_N-1-s), j = k & (t-1).
REQ-020 SHALL set rd_addr_a = (i<<(LOG_N-s)) | j, rd_addr_b = rd_addr_a + t, and tw_addr = m + i.
REQ-021 SHALL go ISSUE->DRAIN after k = N/2-1 is issued; k SHALL NOT wrap or be reissued.
REQ-022 SHALL delay rd_addr_a, rd_addr_b and rd_en through an L = RD_LATENCY+BF_LATENCY stage shift pipeline to produce wr_addr_a, wr_addr_b and wr_en.
REQ-023 SHALL place the first wr_en exactly L cycles after the first rd_en, with wr_en high for exactly N/2 consecutive cycles.
REQ-024 SHALL go DRAIN->DONE in the cycle after the last wr_en, pulse done for one cycle, then return to IDLE.
REQ-025 SHALL accept a start arriving in the DONE cycle and not lose it; it takes effect from IDLE on the next cycle.
REQ-026 SHALL drive rd/tw/wr addresses to 0 whenever the corresponding enable is low.

Reset
REQ-027 SHALL, on rst high, immediately set the FSM to IDLE, clear k, the latched stage and all pipeline valids, and drive busy, done, rd_en, wr_en and all addresses to 0.
REQ-028 SHALL, on reset mid-ISSUE or mid-DRAIN, abort the stage: no further wr_en and no done pulse after rst deasserts.
REQ-029 SHALL accept a new start on the first clock edge after rst deasserts.

Verification (LOG_N=3, RD_LATENCY=1, BF_LATENCY=6, so L=7)
REQ-030 SHALL check stage 0: start at cycle 0 -> rd_en cycles 1-4, pairs (0,4),(1,5),(2,6),(3,7), tw_addr 1,1,1,1; wr_en cycles 8-11 with the same pairs; done at cycle 12.
REQ-031 SHALL check stage 1: pairs (0,2),(1,3),(4,6),(5,7) with tw_addr 2,2,3,3.
REQ-032 SHALL check stage 2: pairs (0,1),(2,3),(4,5),(6,7) with tw_addr 4,5,6,7.
REQ-033 SHALL check that start with stage=3, or start while busy -> no rd_en, busy stays unchanged, no done.
REQ-034 SHALL check that rst asserted at cycle 6 of a stage-0 run -> all outputs 0 at once; no wr_en or done afterwards; a restart afterwards completes normally.
REQ-035 SHALL check back-to-back operation: start in the DONE cycle -> the next stage's rd_en begins two cycles later, and the two runs' write streams do not overlap.
